mem_bridge: RTL
===============

# mem_bridge

Single-port memory slave on the core's picorv32-style native bus. It sits directly downstream of the CPU and serves instruction fetches, loads and stores from an internal word RAM with configurable wait states. It also provides a memory-mapped 8N1 UART transmitter and a sticky flag for accesses to unmapped addresses.

## Interface
- DEPTH, 1024: RAM size in 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 1: extra wait cycles per access, 0..15.
- CLKS_PER_BIT, 16: UART bit period in clk cycles, >= 2.
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  reset, synchronous, active-high.
- mem_valid  input  1  request valid; held by the master until mem_ready.
- mem_instr  input  1  request is an instruction fetch.
- mem_addr  input  32  byte address; bits [1:0] ignored.
- mem_wdata  input  32  write data, byte lane i = bits [8i+7:8i].
- mem_wstrb  input  4  byte write enables; 0 = read.
- mem_ready  output  1  one-cycle completion pulse.
- mem_rdata  output  32  read data, valid while mem_ready=1.
- uart_tx  output  1  serial output, idle high.
- bus_error  output  1  sticky unmapped-access flag.

## Operation
- Address map:
  - RAM: mem_addr < DEPTH*4; word index = mem_addr[log2(DEPTH)+1:2].
  - UART: mem_addr[31:2] == 32'h1000_0000 >> 2.
  - All other addresses are unmapped.
- Effective strobe is 4'b0000 whenever mem_instr=1, so fetches never write.
- States: IDLE, WAIT, STALL, RESP.
- IDLE:
  - If mem_valid=1, latch addr/wdata/strobe/instr and load wait_cnt = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else the access state.
- WAIT: decrement wait_cnt; at 1, go to the access state.
- Access state:
  - RESP for all accesses.
  - Exception: STALL for a UART write with wstrb[0]=1 while uart busy.
- STALL: hold until uart not busy, then go to RESP.
- Edge entering RESP performs the access:
  - RAM read: registered read of the latched word.
  - RAM write: byte lanes with strobe set are written.
  - UART write with wstrb[0]=1: load wdata[7:0] and set busy.
  - UART read: rdata = {31'b0, busy}.
  - Unmapped: rdata = 0, writes dropped, bus_error <= 1.
- RESP: mem_ready=1 for exactly one cycle, then IDLE unconditionally.
  - A request is never re-accepted in the cycle after RESP.
- UART frame:
  - Start bit 0, then data bits LSB first, then stop bit 1.
  - Each bit lasts CLKS_PER_BIT cycles.
  - busy is high from the load edge until the stop bit completes.
- Protocol violations by the master:
  - mem_valid dropped mid-transaction: the latched transaction still completes normally.
  - Inputs changing after acceptance are ignored.

## Timing
- Reset values:
  - mem_ready=0, mem_rdata=0, uart_tx=1, bus_error=0.
  - State IDLE, busy=0, wait_cnt=0.
  - RAM contents are not reset.
- Latency: mem_valid first sampled high in cycle 0 gives mem_ready=1 in cycle WAIT_CYCLES+1.
  - Plus STALL cycles for a UART write while busy.
- Throughput: one transaction per WAIT_CYCLES+2 cycles, minimum.
- mem_rdata holds its last value outside RESP. Write responses return the old RAM word for RAM and 0 for UART.
- Read-after-write to the same word in back-to-back transactions returns the new data.
- The first UART start bit drives uart_tx low in the cycle after the load edge.
- Reset mid-operation:
  - State returns to IDLE; a pending mem_ready is suppressed.
  - uart_tx goes to 1 in the next cycle and any frame in progress is aborted.
  - A RAM write already committed is kept.
- bus_error clears only on reset.

## Test plan
- WAIT_CYCLES=1: sw 0xDEADBEEF to 0x10, then lw 0x10.
  - Each mem_ready arrives in cycle 2 and lasts 1 cycle.
  - The read returns 0xDEADBEEF.
- Byte strobes:
  - Preload 0x11223344 at 0x20; write wdata=0xAABBCCDD with wstrb=4'b0101.
  - Read returns 0x11BB33DD.
- Fetch with mem_instr=1, wstrb=4'b1111 to 0x20: the word is unchanged and the read data is returned.
- UART: sb 0x55 to 0x1000_0000 with CLKS_PER_BIT=4.
  - uart_tx sequence, 4 cycles per bit: 0,1,0,1,0,1,0,1,0,1.
  - Status read during the frame returns 1, and returns 0 after the stop bit.
  - A second sb issued mid-frame stalls mem_ready until the frame ends.
- Unmapped access: lw 0x2000_0000.
  - mem_rdata=0 with mem_ready, then bus_error=1.
  - bus_error stays 1 through subsequent RAM accesses until reset.
- Reset asserted in WAIT and mid-UART-frame:
  - No mem_ready pulse occurs.
  - uart_tx=1 and bus_error=0 the cycle after reset.
  - The next request completes with normal latency.

Source files
------------

// File: rtl/mem_bridge.sv
// Native-bus memory slave: word RAM with configurable wait states, a memory-mapped
// 8N1 UART transmitter and a sticky flag for unmapped accesses.
module mem_bridge #(
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned WAIT_CYCLES  = 1,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        uart_tx,
   output logic        bus_error
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [29:0] UART_WORD = 30'h0400_0000;

   typedef enum logic [1:0] {StIdle, StWait, StStall, StResp} state_e;

   state_e        state_q, state_d;
   logic [3:0]    wait_cnt_q, wait_cnt_d;
   logic [29:0]   word_q;
   logic [31:0]   wdata_q;
   logic [3:0]    strb_q;
   logic          latch_en;
   logic          go_access;
   logic          do_access;

   logic [29:0]   acc_word;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_strb;
   logic [AW-1:0] acc_idx;
   logic          is_ram;
   logic          is_uart;
   logic          is_write;
   logic          uart_wr;

   logic [31:0]   rdata_q;
   logic          bus_error_q;

   logic          busy_q;
   logic          tx_q;
   logic [8:0]    shreg_q;
   logic [3:0]    bit_idx_q;
   logic [CW-1:0] clk_cnt_q;
   logic          uart_load;

   logic          unused_addr;
   assign unused_addr = ^mem_addr[1:0];

   // With zero wait states the access is decided in IDLE, before the latch is loaded.
   always_comb begin
      if (state_q == StIdle) begin
         acc_word  = mem_addr[31:2];
         acc_wdata = mem_wdata;
         acc_strb  = mem_instr ? 4'b0000 : mem_wstrb;
      end else begin
         acc_word  = word_q;
         acc_wdata = wdata_q;
         acc_strb  = strb_q;
      end
   end

   assign acc_idx  = acc_word[AW-1:0];
   assign is_ram   = (acc_word[29:AW] == '0);
   assign is_uart  = (acc_word == UART_WORD);
   assign is_write = |acc_strb;
   assign uart_wr  = is_uart & acc_strb[0];

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      latch_en   = 1'b0;
      go_access  = 1'b0;
      do_access  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mem_valid) begin
               latch_en   = 1'b1;
               wait_cnt_d = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  go_access = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            wait_cnt_d = wait_cnt_q - 4'd1;
            if (wait_cnt_q == 4'd1) begin
               go_access = 1'b1;
            end
         end
         StStall: begin
            if (!busy_q) begin
               state_d   = StResp;
               do_access = 1'b1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (go_access) begin
         if (uart_wr && busy_q) begin
            state_d = StStall;
         end else begin
            state_d   = StResp;
            do_access = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         word_q     <= '0;
         wdata_q    <= '0;
         strb_q     <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (latch_en) begin
            word_q  <= mem_addr[31:2];
            wdata_q <= mem_wdata;
            strb_q  <= mem_instr ? 4'b0000 : mem_wstrb;
         end
      end
   end

   logic [31:0] ram [DEPTH];

   always_ff @(posedge clk) begin
      if (do_access && is_ram && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_strb[i]) begin
               ram[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   // RAM read is taken before the write lands, so write responses carry the old word.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q     <= '0;
         bus_error_q <= 1'b0;
      end else if (do_access) begin
         if (is_ram) begin
            rdata_q <= ram[acc_idx];
         end else if (is_uart) begin
            rdata_q <= is_write ? 32'd0 : {31'd0, busy_q};
         end else begin
            rdata_q     <= '0;
            bus_error_q <= 1'b1;
         end
      end
   end

   assign uart_load = do_access & uart_wr;

   // Shift register holds data then stop bit; the start bit is driven directly on load.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q    <= 1'b0;
         tx_q      <= 1'b1;
         shreg_q   <= '0;
         bit_idx_q <= '0;
         clk_cnt_q <= '0;
      end else if (uart_load) begin
         busy_q    <= 1'b1;
         tx_q      <= 1'b0;
         shreg_q   <= {1'b1, acc_wdata[7:0]};
         bit_idx_q <= '0;
         clk_cnt_q <= '0;
      end else if (busy_q) begin
         if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 4'd9) begin
               busy_q <= 1'b0;
               tx_q   <= 1'b1;
            end else begin
               tx_q      <= shreg_q[0];
               shreg_q   <= {1'b0, shreg_q[8:1]};
               bit_idx_q <= bit_idx_q + 4'd1;
            end
         end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
         end
      end
   end

   assign mem_ready = (state_q == StResp);
   assign mem_rdata = rdata_q;
   assign uart_tx   = tx_q;
   assign bus_error = bus_error_q;

endmodule
